// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/baud constants.
package uart_pkg;

    localparam int DBIT_DEF     = 8;
    localparam int SB_TICK_DEF  = 16;
    localparam int BAUD_DIV_DEF = 163;
    localparam int FIFO_W_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-clk tick every BAUD_DIV clocks, free-running from reset release.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Down-counter: terminal count 0 fires the tick and reloads.
    always_comb begin
        tick  = (cnt_q == '0);
        cnt_d = tick ? CW'(BAUD_DIV - 1) : cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled, LSB first) feeding a first-word fall-through byte FIFO.
// Define UART_RX_PARITY_EN for an even-parity bit after the data bits and a parity_err output.
//
//   state     | meaning
//   ST_IDLE   | line idle, waiting for a low start bit
//   ST_START  | confirming start bit at its midpoint (s=7)
//   ST_DATA   | sampling DBIT data bits every 16 ticks
//   ST_PARITY | sampling the parity bit (parity build only)
//   ST_STOP   | sampling stop bit, then push or flag frame error
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT     = DBIT_DEF,
    parameter int SB_TICK  = SB_TICK_DEF,
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int FIFO_W   = FIFO_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            overrun
);

    localparam int DEPTH = 2 ** FIFO_W;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [FIFO_W:0] FULL_CNT = (FIFO_W + 1)'(DEPTH);
    localparam logic [FIFO_W:0] CNT_ONE  = (FIFO_W + 1)'(1);

    logic tick;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    logic sync1_q, sync2_q;
    logic rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    rx_state_e       state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            ferr_q, ferr_d;
    logic            push;
`ifdef UART_RX_PARITY_EN
    logic            p_q, p_d;
    logic            perr_q, perr_d;
    logic            perr;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_d     = p_q;
        perr_d  = 1'b0;
        perr    = ^{b_q, p_q};
`endif
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        s_d     = '0;
                    end
                end
                ST_START: begin
                    if (s_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
                ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (s_q == 4'd15) begin
                        s_d     = '0;
                        p_d     = rx_s;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                ST_STOP: begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        state_d = ST_IDLE;
                        ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_d  = perr;
                        push    = rx_s & ~perr;
`else
                        push    = rx_s;
`endif
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_q     <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            p_q     <= p_d;
            perr_q  <= perr_d;
`endif
        end
    end

    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [DBIT-1:0]   mem_d [DEPTH];
    logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_W:0]   cnt_q, cnt_d;
    logic              overrun_q, overrun_d;
    logic              empty, full, pop, wr_en;

    // A pop in the same cycle frees the slot, so a push while full still lands.
    always_comb begin
        empty     = (cnt_q == '0);
        full      = (cnt_q == FULL_CNT);
        pop       = rd_uart & ~empty;
        wr_en     = push & (~full | pop);
        mem_d     = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = b_q;
        wr_ptr_d  = wr_ptr_q + FIFO_W'(wr_en);
        rd_ptr_d  = rd_ptr_q + FIFO_W'(pop);
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        overrun_d = overrun_q | (push & full & ~pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign r_data    = empty ? '0 : mem_q[rd_ptr_q];
    assign rx_empty  = empty;
    assign rx_full   = full;
    assign frame_err = ferr_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (8N1 build): transaction-level queue model compared every cycle plus literal checks.
module tb_uart_rx_fifo;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rd_uart = 1'b0;
    logic [7:0] r_data;
    logic       rx_empty, rx_full, frame_err, overrun;

    uart_rx_fifo #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(BD), .FIFO_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_uart   (rd_uart),
        .r_data    (r_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ferr_seen = 0;
    bit run_cmp = 1'b0;

    logic [7:0] mq[$];
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;
    int         ev_cyc = -1;
    bit         ev_ok;
    logic [7:0] ev_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // A frame whose start edge is driven just after tick edge E completes its stop sample
    // 1 (sync/detect) + 8 (half bit) + 9*16 (data + stop) ticks later.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            cyc++;
            m_ferr = 1'b0;
            if (rd_uart && mq.size() > 0) void'(mq.pop_front());
            if (cyc == ev_cyc) begin
                ev_cyc = -1;
                if (!ev_ok)              m_ferr = 1'b1;
                else if (mq.size() < 4)  mq.push_back(ev_data);
                else                     m_ovr = 1'b1;
            end
        end
    end

    initial forever begin
        logic [7:0] exp_rd;
        @(negedge clk);
        if (run_cmp) begin
            exp_rd = (mq.size() > 0) ? mq[0] : 8'h00;
            chk("cycle {r_data,empty,full,ferr,ovr}",
                {r_data, rx_empty, rx_full, frame_err, overrun},
                {exp_rd, mq.size() == 0, mq.size() == 4, m_ferr, m_ovr});
            if (frame_err) ferr_seen++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        run_cmp = 1'b0;
        @(negedge clk);
        #1;
        reset   = 1'b0;
        rx      = 1'b1;
        rd_uart = 1'b0;
        mq.delete();
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        ev_cyc  = -1;
        repeat (3) @(negedge clk);
        chk("reset rx_empty", rx_empty, 1);
        chk("reset overrun", overrun, 0);
        chk("reset r_data", r_data, 0);
        #1;
        reset   = 1'b1;
        cyc     = 0;
        run_cmp = 1'b1;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
        while (((cyc - 1) % BD) != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_ticks(input int n);
        repeat (n * BD) @(posedge clk);
        #1;
    endtask

    // Must be called #1 after a tick edge; returns #1 after the tick edge ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        logic [9:0] bits;
        bits    = {stop_ok, d, 1'b0};
        ev_cyc  = cyc + 153 * BD;
        ev_ok   = stop_ok;
        ev_data = d;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (16 * BD) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic pop1();
        rd_uart = 1'b1;
        @(posedge clk);
        #1;
        rd_uart = 1'b0;
    endtask

    initial begin
        logic [7:0] v77;
        v77 = 8'h77;
        do_reset();

        // single byte, then pop back to empty
        align();
        send_frame(8'h5A, 1'b1);
        chk("t1 r_data", r_data, 8'h5A);
        chk("t1 rx_empty", rx_empty, 0);
        pop1();
        chk("t1 empty after pop", rx_empty, 1);
        chk("t1 r_data after pop", r_data, 8'h00);

        // operand order preserved
        align();
        send_frame(8'h03, 1'b1);
        send_frame(8'hFC, 1'b1);
        send_frame(8'h20, 1'b1);
        chk("t2 head A", r_data, 8'h03);
        pop1();
        chk("t2 head B", r_data, 8'hFC);
        pop1();
        chk("t2 head OP", r_data, 8'h20);
        pop1();
        chk("t2 empty", rx_empty, 1);

        // overflow: fifth byte dropped
        align();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        chk("t3 rx_full", rx_full, 1);
        chk("t3 overrun", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t3 pop order", r_data, 8'(i));
            pop1();
        end
        chk("t3 empty", rx_empty, 1);

        // fifth push coinciding with a pop
        do_reset();
        align();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        chk("t3b full before", rx_full, 1);
        fork
            send_frame(8'h05, 1'b1);
            begin
                repeat (153 * BD - 1) @(posedge clk);
                #1;
                rd_uart = 1'b1;
                @(posedge clk);
                #1;
                rd_uart = 1'b0;
            end
        join
        chk("t3b overrun", overrun, 0);
        chk("t3b rx_full", rx_full, 1);
        for (int i = 2; i <= 5; i++) begin
            chk("t3b pop order", r_data, 8'(i));
            pop1();
        end
        chk("t3b empty", rx_empty, 1);

        // start-bit glitch
        align();
        ferr_seen = 0;
        rx = 1'b0;
        repeat (3 * BD) @(posedge clk);
        #1;
        rx = 1'b1;
        idle_ticks(20);
        chk("t4 no frame_err", ferr_seen, 0);
        chk("t4 no push", rx_empty, 1);

        // bad stop bit, then a good frame
        align();
        ferr_seen = 0;
        send_frame(8'hA5, 1'b0);
        idle_ticks(20);
        chk("t5 frame_err pulses", ferr_seen, 1);
        chk("t5 empty", rx_empty, 1);
        align();
        send_frame(8'h11, 1'b1);
        chk("t5 next byte", r_data, 8'h11);
        pop1();

        // reset in the middle of a frame
        align();
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        chk("t6 queued head", r_data, 8'h31);
        rx = 1'b0;
        repeat (16 * BD) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = v77[i];
            repeat (16 * BD) @(posedge clk);
            #1;
        end
        do_reset();
        align();
        send_frame(8'h42, 1'b1);
        chk("t6 after reset", r_data, 8'h42);
        pop1();
        chk("t6 empty", rx_empty, 1);
        idle_ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive front end of the UART-to-ALU path: deserialises 8N1 frames from the rx pin using a 16x oversampling tick and buffers the bytes in a small FIFO.
Presents the rd_uart / r_data / rx_empty handshake that the operand-collecting interface stage consumes, one byte per operand (A, B, OP).
Sits between the board rx pin and that interface stage.

Parameters:
DBIT, 8, data bits per frame (LSB first)
SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit)
BAUD_DIV, 163, clk cycles per oversampling tick (50 MHz / (19200*16))
FIFO_W, 2, FIFO address width; depth = 2**FIFO_W = 4

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
rx  in  1  serial input, idle high, asynchronous to clk
rd_uart  in  1  pop request; one pop per clk cycle asserted while rx_empty=0
r_data  out  DBIT  head of FIFO (first-word fall-through); 0 while rx_empty=1
rx_empty  out  1  FIFO holds no bytes
rx_full  out  1  FIFO holds 2**FIFO_W bytes
frame_err  out  1  one-cycle pulse when a frame's stop bit samples 0
overrun  out  1  sticky; set when a byte is completed while FIFO full and no pop that cycle

Behaviour:
- Reset (reset=0, async): FSM=IDLE, all counters 0, rd/wr pointers 0, rx_empty=1, rx_full=0, r_data=0, frame_err=0, overrun=0, sync flops=1. Reset mid-frame aborts the frame with nothing pushed.
- rx passes through a 2-flop synchroniser before use; all sampling uses the synchronised value.
- Tick generator: mod-BAUD_DIV counter; tick is a 1-cycle pulse every BAUD_DIV clks, free-running from reset release.
- FSM states, all advancing only on tick:
  - IDLE: synchronised rx=0 -> START, tick count s=0.
  - START: at s=7, rx=0 -> DATA (s=0, n=0); rx=1 -> IDLE (glitch rejected, nothing pushed, no error).
  - DATA: at s=15, shift rx into the MSB of a shift register (LSB-first reception), n++. After DBIT bits -> STOP.
  - STOP: at s=SB_TICK-1, sample rx.
    - rx=1: push the shift register into the FIFO.
    - rx=0: frame_err pulses for 1 clk; byte discarded.
    - Either case -> IDLE.
- Push/pop:
  - Push occurs on the STOP sampling clk; rx_empty drops and r_data is valid on the next clk.
  - Pop when rd_uart=1 and rx_empty=0: rd_ptr++; the new head appears on the next clk. rd_uart while empty is ignored.
  - Push while full without a simultaneous pop: byte dropped, contents unchanged, overrun set (cleared only by reset).
  - Simultaneous push and pop: both performed at any occupancy, count unchanged, including when full (no overrun).
  - Pointers wrap modulo 2**FIFO_W; full/empty derived from the count, not from pointer equality alone.
- Back-to-back frames: a new start bit is accepted on the first tick in IDLE after STOP.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined: the frame carries an even-parity bit after the data bits (new PARITY state, sampled at s=15). Extra output parity_err (1 bit) pulses for 1 clk at STOP when parity mismatches; that byte is discarded.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Decomposition:
- Package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP), default DBIT/SB_TICK/BAUD_DIV constants.
- One sub-module, uart_baud_gen (tick counter), reused later by the transmitter.
- The FIFO stays inline.

Test Plan:
1. BAUD_DIV=4; send 0x5A in 8N1 -> rx_empty falls 1 clk after stop sample; r_data=0x5A; pulse rd_uart 1 clk -> rx_empty=1, r_data=0x00.
2. Send 0x03, 0xFC, 0x20 with no reads -> r_data=0x03; pop thrice -> 0xFC, 0x20, then rx_empty=1 (operand A, B, OP order kept).
3. Send 5 bytes 0x01..0x05 with no reads -> rx_full=1, overrun=1; pops return 0x01..0x04 only. Repeat with a pop coinciding with the 5th push -> no overrun, 0x05 retained.
4. Drive rx low for 3 ticks, then high -> no push, no frame_err, FSM back in IDLE.
5. Send 0xA5 with stop bit 0 -> frame_err 1-clk pulse, rx_empty stays 1. Next valid frame 0x11 is received correctly.
6. Assert reset mid-DATA of frame 0x77 with 2 bytes queued -> rx_empty=1, overrun=0; release and send 0x42 -> r_data=0x42.
